// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: requester ids, priority states and the
// return-routing tag carried down the two-stage pipe.
package mem_arb_pkg;

  localparam int STARVE_W = 4;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } owner_e;

  typedef enum logic {
    PRI_VID = 1'b0,
    PRI_CPU = 1'b1
  } pri_state_e;

  typedef struct packed {
    owner_e owner;
    logic   is_read;
  } tag_t;

  // True when a tag marks a read whose data belongs to the given requester.
  function automatic logic tag_returns(input tag_t t, input owner_e who);
    return (t.owner == who) && t.is_read;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: a lone requester always wins; on contention
// the priority input decides.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       en,
  input  logic       cpu_req,
  input  logic       vid_req,
  input  pri_state_e pri,
  output owner_e     grant
);

  always_comb begin
    grant = OWN_NONE;
    if (en) begin
      if (cpu_req && vid_req) begin
        grant = (pri == PRI_CPU) ? OWN_CPU : OWN_VID;
      end else if (cpu_req) begin
        grant = OWN_CPU;
      end else if (vid_req) begin
        grant = OWN_VID;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU + video) arbiter onto one pipelined memory: accept in N,
// memory command in N+1, read data routed back in N+2.
// MEM_ARBITER_RR_EN selects round-robin contention instead of video priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic              cpu_wide,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_dout,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_dout,
  output logic              mem_en,
  output logic              mem_wr,
  output logic              mem_wide,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output pri_state_e        dbg_pri_state
);

  // Handshake: a requester raises req with stable fields and holds them until
  // ack; ack is combinational in the accepting cycle and the request counts as
  // taken on that rising edge. Returns carry no back-pressure: rvalid is a
  // one-cycle pulse the requester must sample.

  pri_state_e state_q, state_d;
  pri_state_e pick_pri;
  owner_e     grant;

  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic              mem_wide_q, mem_wide_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  tag_t              tag1_q, tag1_d;
  tag_t              tag2_q;

  mem_arb_pick u_pick (
    .en      (~reset),
    .cpu_req (cpu_req),
    .vid_req (vid_req),
    .pri     (pick_pri),
    .grant   (grant)
  );

  // State register and pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= PRI_VID;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_wide_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      tag1_q     <= '{owner: OWN_NONE, is_read: 1'b0};
      tag2_q     <= '{owner: OWN_NONE, is_read: 1'b0};
    end else begin
      state_q    <= state_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_wide_q <= mem_wide_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag1_q;
    end
  end

`ifdef MEM_ARBITER_RR_EN
  logic last_vid_q, last_vid_d;

  // Reset value "video won last" hands the first contention to the CPU.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_vid_q <= 1'b1;
    end else begin
      last_vid_q <= last_vid_d;
    end
  end

  always_comb begin
    state_d    = PRI_VID;
    last_vid_d = last_vid_q;
    if (grant == OWN_CPU) begin
      last_vid_d = 1'b0;
    end else if (grant == OWN_VID) begin
      last_vid_d = 1'b1;
    end
  end

  assign pick_pri = last_vid_q ? PRI_CPU : PRI_VID;
`else
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_q, starve_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Escalate on the edge where the count reaches the limit, so the CPU wins
  // the very next contended cycle.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (!cpu_req || cpu_ack) begin
      starve_d = '0;
      state_d  = PRI_VID;
    end else begin
      if (starve_q != STARVE_LIM) begin
        starve_d = starve_q + STARVE_W'(1);
      end
      if (starve_d == STARVE_LIM) begin
        state_d = PRI_CPU;
      end
    end
  end

  assign pick_pri = state_q;
`endif

  // Acks and the next memory command.
  always_comb begin
    cpu_ack    = (grant == OWN_CPU);
    vid_ack    = (grant == OWN_VID);
    mem_en_d   = 1'b0;
    mem_wr_d   = 1'b0;
    mem_wide_d = 1'b0;
    mem_addr_d = '0;
    mem_din_d  = '0;
    tag1_d     = '{owner: OWN_NONE, is_read: 1'b0};
    case (grant)
      OWN_CPU: begin
        mem_en_d   = 1'b1;
        mem_wr_d   = cpu_wr;
        mem_wide_d = cpu_wide;
        mem_addr_d = cpu_addr;
        mem_din_d  = cpu_din;
        tag1_d     = '{owner: OWN_CPU, is_read: ~cpu_wr};
      end
      OWN_VID: begin
        mem_en_d   = 1'b1;
        mem_wide_d = 1'b1;
        mem_addr_d = vid_addr;
        tag1_d     = '{owner: OWN_VID, is_read: 1'b1};
      end
      default: ;
    endcase
  end

  // Reset also forces outputs low in the cycle it is first seen.
  assign mem_en   = mem_en_q & ~reset;
  assign mem_wr   = mem_wr_q & ~reset;
  assign mem_wide = mem_wide_q & ~reset;
  assign mem_addr = reset ? '0 : mem_addr_q;
  assign mem_din  = reset ? '0 : mem_din_q;

  assign cpu_rvalid = ~reset & tag_returns(tag2_q, OWN_CPU);
  assign vid_rvalid = ~reset & tag_returns(tag2_q, OWN_VID);
  assign cpu_dout   = cpu_rvalid ? mem_dout : '0;
  assign vid_dout   = vid_rvalid ? mem_dout : '0;

  assign dbg_pri_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table with a pipelined
// expectation model, plus hand sequences for mid-flight reset and round-robin.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wr, cpu_wide;
  logic [15:0] cpu_addr, cpu_din;
  logic        cpu_ack, cpu_rvalid;
  logic [15:0] cpu_dout;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic        vid_ack, vid_rvalid;
  logic [15:0] vid_dout;
  logic        mem_en, mem_wr, mem_wide;
  logic [15:0] mem_addr, mem_din;
  logic [15:0] mem_dout;
  pri_state_e  dbg_pri_state;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_req       (cpu_req),
    .cpu_wr        (cpu_wr),
    .cpu_wide      (cpu_wide),
    .cpu_addr      (cpu_addr),
    .cpu_din       (cpu_din),
    .cpu_ack       (cpu_ack),
    .cpu_rvalid    (cpu_rvalid),
    .cpu_dout      (cpu_dout),
    .vid_req       (vid_req),
    .vid_addr      (vid_addr),
    .vid_ack       (vid_ack),
    .vid_rvalid    (vid_rvalid),
    .vid_dout      (vid_dout),
    .mem_en        (mem_en),
    .mem_wr        (mem_wr),
    .mem_wide      (mem_wide),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout),
    .dbg_pri_state (dbg_pri_state)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  logic [15:0] mem_arr [0:65535];

  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= mem_arr[mem_addr];
      if (mem_wr) mem_arr[mem_addr] = mem_din;
    end else begin
      mem_dout <= 16'hDEAD;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        cpu_req, cpu_wr, cpu_wide;
    logic [15:0] cpu_addr, cpu_din;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        exp_cpu_ack, exp_vid_ack;
    logic [15:0] exp_data;
  } vec_t;

  typedef struct packed {
    logic        en, wr, wide;
    logic [15:0] addr, din;
    logic        cpu_rd, vid_rd;
  } stage_t;

  vec_t        vecs[$];
  stage_t      st1, st2;
  logic [15:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic creq, input logic cwr, input logic cwide,
                              input logic [15:0] caddr, input logic [15:0] cdin,
                              input logic vreq, input logic [15:0] vaddr,
                              input logic eca, input logic eva, input logic [15:0] edata);
    vec_t v;
    v.cpu_req = creq;  v.cpu_wr = cwr;  v.cpu_wide = cwide;
    v.cpu_addr = caddr; v.cpu_din = cdin;
    v.vid_req = vreq;  v.vid_addr = vaddr;
    v.exp_cpu_ack = eca; v.exp_vid_ack = eva; v.exp_data = edata;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
  endfunction

  function automatic vec_t both(input logic cpu_wins);
    return mk(1, 0, 1, 16'h0100, 16'h0, 1, 16'h2000, cpu_wins, !cpu_wins,
              cpu_wins ? 16'hBEEF : 16'hA000);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    cpu_req  = v.cpu_req;  cpu_wr  = v.cpu_wr;  cpu_wide = v.cpu_wide;
    cpu_addr = v.cpu_addr; cpu_din = v.cpu_din;
    vid_req  = v.vid_req;  vid_addr = v.vid_addr;
  endtask

  task automatic clear_model();
    st1 = '0;
    st2 = '0;
    exp_q.delete();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    drive(idle());
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  // Apply one vector for one cycle and check acks, the command from the
  // previous cycle and the return from two cycles back.
  task automatic step(input vec_t v, input string tag);
    logic [15:0] d;
    drive(v);
    @(negedge clk);
    check({tag, ".cpu_ack"}, 32'(cpu_ack), 32'(v.exp_cpu_ack));
    check({tag, ".vid_ack"}, 32'(vid_ack), 32'(v.exp_vid_ack));
    check({tag, ".mem_en"},   32'(mem_en),   32'(st1.en));
    check({tag, ".mem_wr"},   32'(mem_wr),   32'(st1.wr));
    check({tag, ".mem_wide"}, 32'(mem_wide), 32'(st1.wide));
    check({tag, ".mem_addr"}, 32'(mem_addr), 32'(st1.addr));
    check({tag, ".mem_din"},  32'(mem_din),  32'(st1.din));
    check({tag, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'(st2.cpu_rd));
    check({tag, ".vid_rvalid"}, 32'(vid_rvalid), 32'(st2.vid_rd));
    d = 16'h0;
    if ((st2.cpu_rd || st2.vid_rd) && exp_q.size() > 0) d = exp_q.pop_front();
    check({tag, ".cpu_dout"}, 32'(cpu_dout), 32'(st2.cpu_rd ? d : 16'h0));
    check({tag, ".vid_dout"}, 32'(vid_dout), 32'(st2.vid_rd ? d : 16'h0));
    st2 = st1;
    st1 = '0;
    if (v.exp_cpu_ack) begin
      st1.en = 1'b1; st1.wr = v.cpu_wr; st1.wide = v.cpu_wide;
      st1.addr = v.cpu_addr; st1.din = v.cpu_din; st1.cpu_rd = !v.cpu_wr;
    end else if (v.exp_vid_ack) begin
      st1.en = 1'b1; st1.wide = 1'b1; st1.addr = v.vid_addr; st1.vid_rd = 1'b1;
    end
    if (st1.cpu_rd || st1.vid_rd) exp_q.push_back(v.exp_data);
    @(posedge clk);
    #1;
  endtask

  // ---------------- test ----------------
  initial begin
    for (int a = 0; a < 65536; a++) mem_arr[a] = 16'h0;
    mem_arr[16'h0100] = 16'hBEEF;
    mem_arr[16'h2000] = 16'hA000;
    mem_arr[16'h2002] = 16'hA002;
    mem_arr[16'h2004] = 16'hA004;
    st1 = '0;
    st2 = '0;

    // CPU-only read
    vecs.push_back(mk(1, 0, 1, 16'h0100, 16'h0, 0, 16'h0, 1, 0, 16'hBEEF));
    vecs.push_back(idle());
    vecs.push_back(idle());
    // video back-to-back reads
    vecs.push_back(mk(0, 0, 0, 16'h0, 16'h0, 1, 16'h2000, 0, 1, 16'hA000));
    vecs.push_back(mk(0, 0, 0, 16'h0, 16'h0, 1, 16'h2002, 0, 1, 16'hA002));
    vecs.push_back(mk(0, 0, 0, 16'h0, 16'h0, 1, 16'h2004, 0, 1, 16'hA004));
    vecs.push_back(idle());
    vecs.push_back(idle());
    // wide write, readback, then a narrow read
    vecs.push_back(mk(1, 1, 1, 16'h0011, 16'h1234, 0, 16'h0, 1, 0, 16'h0));
    vecs.push_back(idle());
    vecs.push_back(mk(1, 0, 1, 16'h0011, 16'h0, 0, 16'h0, 1, 0, 16'h1234));
    vecs.push_back(mk(1, 0, 0, 16'h0100, 16'h0, 0, 16'h0, 1, 0, 16'hBEEF));
    vecs.push_back(idle());
    vecs.push_back(idle());
`ifndef MEM_ARBITER_RR_EN
    // continuous contention: four video wins then one CPU win
    for (int k = 0; k < 10; k++) vecs.push_back(both((k % 5) == 4));
    vecs.push_back(idle());
    // CPU drops its request unacked: starvation count restarts
    vecs.push_back(both(0));
    vecs.push_back(both(0));
    vecs.push_back(mk(0, 0, 0, 16'h0, 16'h0, 1, 16'h2000, 0, 1, 16'hA000));
    for (int k = 0; k < 5; k++) vecs.push_back(both(k == 4));
    // lone video request while CPU has priority still wins
    for (int k = 0; k < 4; k++) vecs.push_back(both(0));
    vecs.push_back(mk(0, 0, 0, 16'h0, 16'h0, 1, 16'h2000, 0, 1, 16'hA000));
    vecs.push_back(both(0));
`endif
    vecs.push_back(idle());
    vecs.push_back(idle());

    // reset state
    do_reset(3);
    check("reset.dbg_state", 32'(dbg_pri_state), 32'(PRI_VID));
    step(idle(), "reset");

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i));

    // reset lands in N+1 of a CPU read; accept again right after release
    step(mk(1, 0, 1, 16'h0100, 16'h0, 0, 16'h0, 1, 0, 16'hBEEF), "mid_rst.acc");
    reset = 1'b1;
    vid_req = 1'b1;
    vid_addr = 16'h2000;
    @(negedge clk);
    check("mid_rst.n1.cpu_ack", 32'(cpu_ack), 32'd0);
    check("mid_rst.n1.vid_ack", 32'(vid_ack), 32'd0);
    check("mid_rst.n1.mem_en", 32'(mem_en), 32'd0);
    check("mid_rst.n1.mem_addr", 32'(mem_addr), 32'd0);
    check("mid_rst.n1.mem_wide", 32'(mem_wide), 32'd0);
    check("mid_rst.n1.cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_rst.n2.cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("mid_rst.n2.cpu_dout", 32'(cpu_dout), 32'd0);
    check("mid_rst.n2.vid_rvalid", 32'(vid_rvalid), 32'd0);
    check("mid_rst.n2.cpu_ack", 32'(cpu_ack), 32'd0);
    check("mid_rst.n2.mem_en", 32'(mem_en), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    vid_req = 1'b0;
    clear_model();
    step(mk(1, 0, 1, 16'h0100, 16'h0, 0, 16'h0, 1, 0, 16'hBEEF), "post_rst.acc");
    step(idle(), "post_rst.i0");
    step(idle(), "post_rst.i1");

`ifdef MEM_ARBITER_RR_EN
    // round-robin contention starts with the CPU
    do_reset(2);
    for (int k = 0; k < 6; k++) step(both((k % 2) == 0), $sformatf("rr%0d", k));
    step(idle(), "rr.i0");
    step(idle(), "rr.i1");
`else
    // priority state walk under sustained contention
    do_reset(2);
    for (int k = 0; k < 4; k++) step(both(0), $sformatf("esc%0d", k));
    check("esc.dbg_state", 32'(dbg_pri_state), 32'(PRI_CPU));
    step(both(1), "esc.cpu");
    check("esc.back_dbg_state", 32'(dbg_pri_state), 32'(PRI_VID));
    step(idle(), "esc.i0");
    step(idle(), "esc.i1");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
